// File: rtl/spindle_cfg_pkg.sv
// Shared constants for the spindle parameter sequencer: bank layout,
// reset values of the coefficient bank and the sequencer state encoding.
package spindle_cfg_pkg;

   localparam int SP_NPARAM = 9;
   localparam int SP_AW     = 4;
   localparam int SP_DEPTH  = 4;

   localparam int P_PPS_IA      = 0;
   localparam int P_PPS_II      = 1;
   localparam int P_GAIN        = 2;
   localparam int P_GAMMA_DYN   = 3;
   localparam int P_GAMMA_STA   = 4;
   localparam int P_GAIN_MN     = 5;
   localparam int P_BDAMP1      = 6;
   localparam int P_BDAMP2      = 7;
   localparam int P_BDAMP_CHAIN = 8;

   // Index 0 occupies the least significant word.
   localparam logic [SP_NPARAM*32-1:0] DEFAULTS = {
      32'h3C5844D0, 32'h3D144674, 32'h3E714120,
      32'h00000001, 32'h42A00000, 32'h42A00000,
      32'h00000000, 32'h3F666666, 32'h3F666666
   };

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DRAIN  = 2'd1,
      ST_COMMIT = 2'd2
   } seq_state_e;

   function automatic logic [31:0] default_param(input int idx);
      return DEFAULTS[32*idx +: 32];
   endfunction

endpackage

// File: rtl/spindle_param_sequencer_cfg_fifo.sv
// Synchronous FIFO holding queued {addr,data} parameter writes.
// Pointers carry one extra wrap bit so full and empty are distinguishable.
module cfg_fifo #(
   parameter int W     = 36,
   parameter int DEPTH = 4,
   localparam int PW   = $clog2(DEPTH) + 1
) (
   input  logic          sim_clk,
   input  logic          reset_global,
   input  logic          i_push,
   input  logic [W-1:0]  i_wdata,
   input  logic          i_pop,
   output logic [W-1:0]  o_rdata,
   output logic          o_full,
   output logic          o_empty,
   output logic [PW-1:0] o_count
);

   logic [W-1:0]  r_mem [DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;

   always_ff @(posedge sim_clk or posedge reset_global) begin
      if (reset_global) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
      end else begin
         if (i_push && !o_full)
            r_wr_ptr <= r_wr_ptr + 1'b1;
         if (i_pop && !o_empty)
            r_rd_ptr <= r_rd_ptr + 1'b1;
      end
   end

   always_ff @(posedge sim_clk) begin
      if (i_push && !o_full)
         r_mem[r_wr_ptr[PW-2:0]] <= i_wdata;
   end

   assign o_rdata = r_mem[r_rd_ptr[PW-2:0]];
   assign o_empty = (r_wr_ptr == r_rd_ptr);
   assign o_full  = (r_wr_ptr[PW-1] != r_rd_ptr[PW-1]) &&
                    (r_wr_ptr[PW-2:0] == r_rd_ptr[PW-2:0]);
   assign o_count = r_wr_ptr - r_rd_ptr;

endmodule

// File: rtl/spindle_param_sequencer.sv
// Queues host parameter writes, drains them into a shadow bank on commit and
// copies shadow to active in one edge so consumers never see a partial update.
//   state  | meaning
//   IDLE   | accepting writes, waiting for commit or a pending commit
//   DRAIN  | popping one queued write per edge into shadow
//   COMMIT | active <= shadow, param_update pulses
module spindle_param_sequencer
   import spindle_cfg_pkg::*;
#(
   parameter int NPARAM = SP_NPARAM,
   parameter int AW     = SP_AW,
   parameter int DEPTH  = SP_DEPTH
) (
   input  logic                   sim_clk,
   input  logic                   reset_global,
   input  logic                   cfg_valid,
   input  logic [AW-1:0]          cfg_addr,
   input  logic [31:0]            cfg_data,
   output logic                   cfg_ready,
   input  logic                   commit,
   output logic [NPARAM*32-1:0]   param_active,
   output logic                   param_update,
   output logic                   busy,
   output logic [$clog2(DEPTH):0] pending_cnt,
   output logic                   err_overflow,
   output logic                   err_addr
);

   seq_state_e       r_state;
   seq_state_e       w_state_nxt;
   logic             w_push;
   logic             w_pop;
   logic             w_full;
   logic             w_empty;
   logic             w_addr_ok;
   logic [AW+31:0]   w_rd_entry;
   logic [AW-1:0]    w_pop_addr;
   logic [31:0]      w_pop_data;
   logic [31:0]      r_shadow [NPARAM];
   logic [31:0]      r_active [NPARAM];
   logic             r_commit_pend;
   logic             r_busy;
   logic             r_update;
   logic             r_err_ovf;
   logic             r_err_addr;

   assign cfg_ready  = (r_state == ST_IDLE) && !w_full;
   assign w_push     = cfg_valid && cfg_ready;
   assign w_pop_addr = w_rd_entry[AW+31:32];
   assign w_pop_data = w_rd_entry[31:0];
   assign w_addr_ok  = {{(32-AW){1'b0}}, w_pop_addr} < 32'(NPARAM);

   cfg_fifo #(
      .W     (AW + 32),
      .DEPTH (DEPTH)
   ) u_fifo (
      .sim_clk      (sim_clk),
      .reset_global (reset_global),
      .i_push       (w_push),
      .i_wdata      ({cfg_addr, cfg_data}),
      .i_pop        (w_pop),
      .o_rdata      (w_rd_entry),
      .o_full       (w_full),
      .o_empty      (w_empty),
      .o_count      (pending_cnt)
   );

   always_comb begin
      w_state_nxt = r_state;
      w_pop       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (commit || r_commit_pend)
               w_state_nxt = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (!w_empty)
               w_pop = 1'b1;
            else
               w_state_nxt = ST_COMMIT;
         end
         ST_COMMIT: w_state_nxt = ST_IDLE;
         default:   w_state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge sim_clk or posedge reset_global) begin
      if (reset_global) begin
         r_state       <= ST_IDLE;
         r_commit_pend <= 1'b0;
         r_busy        <= 1'b0;
         r_update      <= 1'b0;
         r_err_ovf     <= 1'b0;
         r_err_addr    <= 1'b0;
         for (int i = 0; i < NPARAM; i++) begin
            r_shadow[i] <= default_param(i);
            r_active[i] <= default_param(i);
         end
      end else begin
         r_state  <= w_state_nxt;
         r_busy   <= (w_state_nxt != ST_IDLE);
         r_update <= (r_state == ST_COMMIT);
         // Commits arriving while busy collapse into a single follow-up pass.
         if (r_state == ST_IDLE && w_state_nxt == ST_DRAIN)
            r_commit_pend <= 1'b0;
         else if (commit && r_state != ST_IDLE)
            r_commit_pend <= 1'b1;
         if (cfg_valid && !cfg_ready)
            r_err_ovf <= 1'b1;
         if (w_pop) begin
            if (w_addr_ok)
               r_shadow[w_pop_addr] <= w_pop_data;
            else
               r_err_addr <= 1'b1;
         end
         if (r_state == ST_COMMIT) begin
            for (int i = 0; i < NPARAM; i++)
               r_active[i] <= r_shadow[i];
         end
      end
   end

   for (genvar g = 0; g < NPARAM; g++) begin : g_flat
      assign param_active[32*g +: 32] = r_active[g];
   end

   assign param_update = r_update;
   assign busy         = r_busy;
   assign err_overflow = r_err_ovf;
   assign err_addr     = r_err_addr;

endmodule

// File: tb/tb_spindle_param_sequencer.sv
// Self-checking bench for spindle_param_sequencer: directed vector table,
// corner-case sequences and random traffic against a transaction-level model.
module tb_spindle_param_sequencer;

   localparam int NP = 9;
   localparam int DP = 4;
   localparam logic [31:0] TB_DEF [NP] = '{
      32'h3F666666, 32'h3F666666, 32'h00000000, 32'h42A00000, 32'h42A00000,
      32'h00000001, 32'h3E714120, 32'h3D144674, 32'h3C5844D0
   };

   logic            sim_clk = 1'b0;
   logic            reset_global = 1'b1;
   logic            cfg_valid = 1'b0;
   logic [3:0]      cfg_addr = '0;
   logic [31:0]     cfg_data = '0;
   logic            cfg_ready;
   logic            commit = 1'b0;
   logic [NP*32-1:0] param_active;
   logic            param_update;
   logic            busy;
   logic [2:0]      pending_cnt;
   logic            err_overflow;
   logic            err_addr;

   spindle_param_sequencer dut (
      .sim_clk      (sim_clk),
      .reset_global (reset_global),
      .cfg_valid    (cfg_valid),
      .cfg_addr     (cfg_addr),
      .cfg_data     (cfg_data),
      .cfg_ready    (cfg_ready),
      .commit       (commit),
      .param_active (param_active),
      .param_update (param_update),
      .busy         (busy),
      .pending_cnt  (pending_cnt),
      .err_overflow (err_overflow),
      .err_addr     (err_addr)
   );

   always #5 sim_clk = ~sim_clk;

   int n_checks = 0;
   int n_errors = 0;

   // Transaction-level model: a write queue, a countdown for the pass in
   // progress, and the shadow/active banks as plain arrays.
   typedef struct { logic [3:0] a; logic [31:0] d; } ent_t;
   ent_t        m_q[$];
   logic [31:0] m_sh [NP];
   logic [31:0] m_act [NP];
   int          m_rem;
   bit          m_pend, m_upd, m_eo, m_ea;

   typedef struct {
      bit v; logic [3:0] a; logic [31:0] d; bit c;
      bit e_upd; bit e_busy; int e_pend; logic [31:0] e_p3; logic [31:0] e_p6;
   } vec_t;

   function automatic logic [31:0] act_word(input int i);
      return param_active[32*i +: 32];
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
      n_checks++;
      if (got !== want) begin
         n_errors++;
         $display("FAIL %s: got %h, want %h", name, got, want);
      end
   endtask

   task automatic model_reset();
      m_q.delete();
      m_rem = 0; m_pend = 0; m_upd = 0; m_eo = 0; m_ea = 0;
      for (int i = 0; i < NP; i++) begin
         m_sh[i] = TB_DEF[i];
         m_act[i] = TB_DEF[i];
      end
   endtask

   task automatic model_edge(input bit v, input logic [3:0] a, input logic [31:0] d,
                             input bit c, input bit rdy);
      ent_t e;
      m_upd = 0;
      if (m_rem == 0) begin
         if (v) begin
            if (rdy) m_q.push_back('{a, d});
            else     m_eo = 1;
         end
         if (c || m_pend) begin
            m_pend = 0;
            m_rem = m_q.size() + 2;
         end
      end else begin
         if (v) m_eo = 1;
         if (c) m_pend = 1;
         if (m_rem > 2) begin
            e = m_q.pop_front();
            if (int'(e.a) < NP) m_sh[e.a] = e.d;
            else                m_ea = 1;
         end else if (m_rem == 1) begin
            m_act = m_sh;
            m_upd = 1;
         end
         m_rem--;
      end
   endtask

   task automatic check_all();
      for (int i = 0; i < NP; i++)
         chk($sformatf("active[%0d]", i), act_word(i), m_act[i]);
      chk("param_update", 32'(param_update), 32'(m_upd));
      chk("busy", 32'(busy), 32'(m_rem != 0));
      chk("pending_cnt", 32'(pending_cnt), 32'(m_q.size()));
      chk("err_overflow", 32'(err_overflow), 32'(m_eo));
      chk("err_addr", 32'(err_addr), 32'(m_ea));
   endtask

   // Called at a negative edge; returns at the following negative edge.
   task automatic step(input bit v, input logic [3:0] a, input logic [31:0] d, input bit c);
      bit rdy;
      cfg_valid = v; cfg_addr = a; cfg_data = d; commit = c;
      rdy = (m_rem == 0) && (m_q.size() < DP);
      chk("cfg_ready", 32'(cfg_ready), 32'(rdy));
      @(posedge sim_clk);
      model_edge(v, a, d, c, rdy);
      @(negedge sim_clk);
      cfg_valid = 0; commit = 0;
      check_all();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 4'd0, 32'd0, 0);
   endtask

   task automatic do_reset();
      reset_global = 1;
      #1;
      model_reset();
      check_all();
      @(posedge sim_clk);
      @(negedge sim_clk);
      reset_global = 0;
      check_all();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vec_t tbl[8];
      int   pulses;
      tbl[0] = '{1, 4'd3, 32'h42C80000, 0, 0, 0, 1, 32'h42A00000, 32'h3E714120};
      tbl[1] = '{1, 4'd6, 32'h3E800000, 0, 0, 0, 2, 32'h42A00000, 32'h3E714120};
      tbl[2] = '{0, 4'd0, 32'h0,        1, 0, 1, 2, 32'h42A00000, 32'h3E714120};
      tbl[3] = '{0, 4'd0, 32'h0,        0, 0, 1, 1, 32'h42A00000, 32'h3E714120};
      tbl[4] = '{0, 4'd0, 32'h0,        0, 0, 1, 0, 32'h42A00000, 32'h3E714120};
      tbl[5] = '{0, 4'd0, 32'h0,        0, 0, 1, 0, 32'h42A00000, 32'h3E714120};
      tbl[6] = '{0, 4'd0, 32'h0,        0, 1, 0, 0, 32'h42C80000, 32'h3E800000};
      tbl[7] = '{0, 4'd0, 32'h0,        0, 0, 0, 0, 32'h42C80000, 32'h3E800000};

      model_reset();
      repeat (2) @(posedge sim_clk);
      @(negedge sim_clk);
      reset_global = 0;
      check_all();
      chk("reset_p3", act_word(3), 32'h42A00000);
      chk("reset_p8", act_word(8), 32'h3C5844D0);

      // Two writes then commit: active changes on the 4th edge after commit.
      for (int i = 0; i < 8; i++) begin
         step(tbl[i].v, tbl[i].a, tbl[i].d, tbl[i].c);
         chk($sformatf("vec%0d_upd", i), 32'(param_update), 32'(tbl[i].e_upd));
         chk($sformatf("vec%0d_busy", i), 32'(busy), 32'(tbl[i].e_busy));
         chk($sformatf("vec%0d_pend", i), 32'(pending_cnt), 32'(tbl[i].e_pend));
         chk($sformatf("vec%0d_p3", i), act_word(3), tbl[i].e_p3);
         chk($sformatf("vec%0d_p6", i), act_word(6), tbl[i].e_p6);
      end

      // Overflow: fifth write refused and dropped.
      step(1, 4'd0, 32'hA0000000, 0);
      step(1, 4'd1, 32'hA1111111, 0);
      step(1, 4'd2, 32'hA2222222, 0);
      step(1, 4'd5, 32'hA5555555, 0);
      chk("full_ready", 32'(cfg_ready), 32'd0);
      step(1, 4'd7, 32'hA7777777, 0);
      chk("ovf_flag", 32'(err_overflow), 32'd1);
      chk("ovf_pend", 32'(pending_cnt), 32'd4);
      step(0, 4'd0, 32'd0, 1);
      idle(7);
      chk("ovf_p7_kept", act_word(7), 32'h3D144674);
      chk("ovf_p5", act_word(5), 32'hA5555555);

      // Illegal address is discarded but the legal write lands.
      step(1, 4'd12, 32'hDEADBEEF, 0);
      step(1, 4'd4, 32'h41200000, 0);
      step(0, 4'd0, 32'd0, 1);
      idle(5);
      chk("bad_addr_flag", 32'(err_addr), 32'd1);
      chk("bad_addr_p4", act_word(4), 32'h41200000);

      // Same-edge write+commit, plus a commit while draining.
      step(1, 4'd2, 32'h11111111, 0);
      step(1, 4'd8, 32'h88888888, 1);
      step(0, 4'd0, 32'd0, 1);
      pulses = 0;
      for (int i = 0; i < 12; i++) begin
         step(0, 4'd0, 32'd0, 0);
         if (param_update) begin
            pulses++;
            if (pulses == 1) chk("same_edge_incl", act_word(8), 32'h88888888);
         end
      end
      chk("two_pulses", 32'(pulses), 32'd2);

      // Reset in the middle of a drain.
      step(1, 4'd0, 32'hBBBB0000, 0);
      step(1, 4'd1, 32'hBBBB0001, 0);
      step(1, 4'd3, 32'hBBBB0003, 0);
      step(0, 4'd0, 32'd0, 1);
      chk("pre_reset_busy", 32'(busy), 32'd1);
      do_reset();
      chk("rst_pend", 32'(pending_cnt), 32'd0);
      chk("rst_p3", act_word(3), 32'h42A00000);
      pulses = 0;
      for (int i = 0; i < 8; i++) begin
         step(0, 4'd0, 32'd0, 0);
         if (param_update) pulses++;
      end
      chk("rst_no_pulse", 32'(pulses), 32'd0);

      // Random traffic against the model.
      for (int i = 0; i < 600; i++) begin
         step(bit'($urandom_range(0, 1)), 4'($urandom_range(0, 10)), $urandom,
              ($urandom_range(0, 7) == 0));
         if (i == 300) do_reset();
      end
      idle(10);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
